// File: rtl/adc_capture_pkg.sv
// Shared constants for the AD9276 triggered capture controller.
// FSM state encodings, per-channel FIFO lane width and default geometry.
package adc_capture_pkg;

    localparam int NCH_DEF   = 8;
    localparam int DW_DEF    = 14;
    localparam int CNT_W_DEF = 16;
    localparam int CH_PAD    = 16;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ARMED   = 3'd1;
    localparam state_t ST_DELAY   = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/adc_capture_pack.sv
// Registered frame packer: zero-extends each channel into a 16-bit FIFO lane.
// With ADC_CAPTURE_TESTPAT_EN defined, din is replaced by a per-channel ramp.
module adc_capture_pack
    import adc_capture_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    keep_i,
    input  logic                    wr_i,
    input  logic [NCH*DW-1:0]       din_i,
    output logic                    fifo_wen_o,
    output logic [NCH*CH_PAD-1:0]   fifo_wdata_o
);

    logic [NCH*CH_PAD-1:0] wdata_d;

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [DW-1:0] frame_idx_q;
    logic          unused_din;

    assign unused_din = ^din_i;

    // Channel ch is offset by ch*1024 so each lane is identifiable in the dump.
    always_comb begin
        wdata_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            wdata_d[ch*CH_PAD +: CH_PAD] = CH_PAD'(frame_idx_q + DW'(ch * 1024));
        end
    end

    // Dropped (overflowed) frames still advance the ramp, keeping it aligned in time.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            frame_idx_q <= '0;
        end else if (keep_i) begin
            frame_idx_q <= frame_idx_q + DW'(1);
        end
    end
`else
    logic unused_ctrl;

    assign unused_ctrl = ^{clr_i, keep_i};

    always_comb begin
        wdata_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            wdata_d[ch*CH_PAD +: CH_PAD] = CH_PAD'(din_i[ch*DW +: DW]);
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wen_o   <= 1'b0;
            fifo_wdata_o <= '0;
        end else begin
            fifo_wen_o <= wr_i;
            if (wr_i) begin
                fifo_wdata_o <= wdata_d;
            end
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Triggered capture controller downstream of the AD9276 deserializer.
// Optional ramp test pattern: define ADC_CAPTURE_TESTPAT_EN.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din_valid,
    input  logic [NCH*DW-1:0]      din,
    input  logic                   dco_locked,
    input  logic                   fco_locked,
    input  logic                   arm,
    input  logic                   trig,
    input  logic [CNT_W-1:0]       delay,
    input  logic [CNT_W-1:0]       nsamp,
    input  logic [3:0]             decim,
    input  logic                   fifo_full,
    output logic                   fifo_wen,
    output logic [NCH*CH_PAD-1:0]  fifo_wdata,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   lock_lost
);

    state_t           state_q, state_d;
    logic             trig_q;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] nsamp_q, nsamp_d;
    logic [3:0]       decim_q, decim_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [3:0]       dec_q, dec_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             ll_q, ll_d;
    logic             locks_ok, trig_rise;
    logic             keep, wr, cap_start;

    assign locks_ok  = dco_locked & fco_locked;
    assign trig_rise = trig & ~trig_q;

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        nsamp_d   = nsamp_q;
        decim_d   = decim_q;
        dcnt_d    = dcnt_q;
        scnt_d    = scnt_q;
        dec_d     = dec_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        ll_d      = ll_q;
        keep      = 1'b0;
        wr        = 1'b0;
        cap_start = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    if (locks_ok) begin
                        state_d = ST_ARMED;
                        done_d  = 1'b0;
                        ovf_d   = 1'b0;
                        ll_d    = 1'b0;
                        delay_d = delay;
                        nsamp_d = nsamp;
                        decim_d = decim;
                    end else begin
                        ll_d = 1'b1;
                    end
                end
            end
            ST_ARMED, ST_DELAY, ST_CAPTURE: begin
                // Lock loss pre-empts everything, including a frame in this same cycle.
                if (!locks_ok) begin
                    state_d = ST_IDLE;
                    ll_d    = 1'b1;
                    done_d  = 1'b0;
                end else if (state_q == ST_ARMED) begin
                    if (trig_rise) begin
                        if (nsamp_q == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else if (delay_q != '0) begin
                            state_d = ST_DELAY;
                            dcnt_d  = '0;
                        end else begin
                            state_d   = ST_CAPTURE;
                            cap_start = 1'b1;
                        end
                    end
                end else if (state_q == ST_DELAY) begin
                    if (din_valid) begin
                        dcnt_d = dcnt_q + CNT_W'(1);
                        if (dcnt_q + CNT_W'(1) == delay_q) begin
                            state_d   = ST_CAPTURE;
                            cap_start = 1'b1;
                        end
                    end
                end else if (din_valid) begin
                    dec_d = (dec_q == decim_q) ? 4'd0 : dec_q + 4'd1;
                    if (dec_q == 4'd0) begin
                        keep   = 1'b1;
                        wr     = ~fifo_full;
                        ovf_d  = ovf_q | fifo_full;
                        scnt_d = scnt_q + CNT_W'(1);
                        if (scnt_q + CNT_W'(1) == nsamp_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cap_start) begin
            dec_d  = 4'd0;
            scnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
            delay_q <= '0;
            nsamp_q <= '0;
            decim_q <= '0;
            dcnt_q  <= '0;
            scnt_q  <= '0;
            dec_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ll_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            delay_q <= delay_d;
            nsamp_q <= nsamp_d;
            decim_q <= decim_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            ll_q    <= ll_d;
        end
    end

    assign busy      = (state_q == ST_ARMED) || (state_q == ST_DELAY) || (state_q == ST_CAPTURE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign lock_lost = ll_q;

    adc_capture_pack #(
        .NCH (NCH),
        .DW  (DW)
    ) u_pack (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (cap_start),
        .keep_i       (keep),
        .wr_i         (wr),
        .din_i        (din),
        .fifo_wen_o   (fifo_wen),
        .fifo_wdata_o (fifo_wdata)
    );

endmodule
